// File: rtl/fifo_packer_pkg.sv
// Shared types and defaults for the FIFO read-side word packer.
package fifo_packer_pkg;

    localparam int DEF_DSIZE   = 8;
    localparam int DEF_LANES   = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LAST
    } acc_state_t;

    // Keep mask carries one bit per lane.
    function automatic int keep_width(input int lanes);
        return lanes;
    endfunction

endpackage

// File: rtl/packer_timeout.sv
// Idle counter for partial-word flush; saturates at TIMEOUT and raises expire.
module packer_timeout
    import fifo_packer_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic rclk,
    input  logic rrst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] cnt;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

    assign expire = (cnt == LIMIT);

endmodule

// File: rtl/fifo_word_packer.sv
// Packs LANES consecutive FIFO entries into one valid/ready output word.
// Optional partial-word flush on idle: define FIFO_WORD_PACKER_TIMEOUT_EN.
module fifo_word_packer
    import fifo_packer_pkg::*;
#(
    parameter int DSIZE   = DEF_DSIZE,
    parameter int LANES   = DEF_LANES,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                          rclk,
    input  logic                          rrst,
    input  logic [DSIZE-1:0]              rdata,
    input  logic                          rempty,
    output logic                          rinc,
    output logic [DSIZE*LANES-1:0]        out_data,
    output logic [keep_width(LANES)-1:0]  out_keep,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST_CNT = CW'(LANES - 1);

    if (LANES < 2 || TIMEOUT < 1) begin : g_param_err
        $error("fifo_word_packer: LANES must be >= 2 and TIMEOUT >= 1");
    end

    logic [CW-1:0]                 acc_cnt, acc_nxt;
    logic [LANES-2:0][DSIZE-1:0]   lanes;
    acc_state_t                    acc_state;
    logic                          out_free, pop, load, flush;
    logic [LANES-1:0][DSIZE-1:0]   flush_data;
    logic [LANES-1:0]              flush_keep;

    always_comb begin
        acc_state = IDLE;
        if (acc_cnt == LAST_CNT)
            acc_state = LAST;
        else if (acc_cnt != '0)
            acc_state = FILL;
    end

    assign out_free = !out_valid || out_ready;
    // Held low during reset so no entry is consumed by a packer that will discard it.
    assign pop      = !rrst && !rempty && (acc_state != LAST || out_free);
    assign rinc     = pop;
    assign load     = pop && acc_state == LAST;

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
    logic expire;

    packer_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .rclk   (rclk),
        .rrst   (rrst),
        .clear  (pop || acc_state == IDLE || flush),
        .enable (acc_state != IDLE),
        .expire (expire)
    );

    // A pop in the same cycle wins over the flush.
    assign flush = expire && acc_state != IDLE && out_free && !pop;

    always_comb begin
        flush_data = '0;
        flush_keep = '0;
        for (int i = 0; i < LANES - 1; i++) begin
            if (CW'(i) < acc_cnt) begin
                flush_data[i] = lanes[i];
                flush_keep[i] = 1'b1;
            end
        end
    end
`else
    assign flush      = 1'b0;
    assign flush_data = '0;
    assign flush_keep = '0;
`endif

    always_comb begin
        acc_nxt = acc_cnt;
        if (load || flush)
            acc_nxt = '0;
        else if (pop)
            acc_nxt = acc_cnt + 1'b1;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst)
            acc_cnt <= '0;
        else
            acc_cnt <= acc_nxt;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            lanes <= '0;
        end else if (pop && acc_state != LAST) begin
            for (int i = 0; i < LANES - 1; i++)
                if (acc_cnt == CW'(i))
                    lanes[i] <= rdata;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= {rdata, lanes};
            out_keep  <= '1;
        end else if (flush) begin
            out_valid <= 1'b1;
            out_data  <= flush_data;
            out_keep  <= flush_keep;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_keep  <= '0;
        end
    end

endmodule
